// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and default sizing for the round-robin register write arbiter.
package reg_write_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_WIDTH = 8;

    // A single requester still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from ptr, wrapping.
module rr_pick
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int PTR_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // Explicit modulo keeps the wrap correct for non-power-of-two N_REQ.
            idx = PTR_W'((int'(ptr) + i) % N_REQ);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shared-register write arbiter: IDLE picks a round-robin winner, WRITE commits its data, DONE acks.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic                   busy
);

    localparam int PTR_W = idx_width(N_REQ);

    state_t           state, state_next;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;

    rr_pick #(
        .N_REQ(N_REQ),
        .PTR_W(PTR_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .winner(pick_idx),
        .valid (pick_valid)
    );

    // Reset wins over everything, so a transaction caught mid-flight never writes q or acks.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            winner <= '0;
            q      <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE:    if (pick_valid) winner <= pick_idx;
                WRITE:   q <= wdata[int'(winner)*WIDTH +: WIDTH];
                DONE:    ptr <= PTR_W'((int'(winner) + 1) % N_REQ);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = WRITE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        ack = '0;
        if (state == WRITE) gnt[winner] = 1'b1;
        if (state == DONE)  ack[winner] = 1'b1;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized requesters against a transaction-level model.
module tb_reg_write_arbiter;
    import reg_write_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: m_left counts the cycles still owed to the current write (2 = grant cycle, 1 = ack cycle).
    int           m_left = 0;
    int           m_win  = 0;
    int           m_ptr  = 0;
    logic [W-1:0] m_q    = '0;

    reg_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .req  (req),
        .wdata(wdata),
        .gnt  (gnt),
        .ack  (ack),
        .q    (q),
        .busy (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_left = 0;
            m_ptr  = 0;
            m_q    = '0;
        end else if (m_left == 2) begin
            m_q    = wdata[m_win*W +: W];
            m_left = 1;
        end else if (m_left == 1) begin
            m_ptr  = (m_win + 1) % N;
            m_left = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (m_left == 0 && req[(m_ptr + k) % N]) begin
                    m_win  = (m_ptr + k) % N;
                    m_left = 2;
                end
            end
        end
    endtask

    // One clock: advance the model on the edge, then compare all outputs 1 time unit later.
    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check("gnt",  32'(gnt),  (m_left == 2) ? (32'd1 << m_win) : 32'd0);
        check("ack",  32'(ack),  (m_left == 1) ? (32'd1 << m_win) : 32'd0);
        check("q",    32'(q),    32'(m_q));
        check("busy", 32'(busy), 32'(m_left != 0));
    endtask

    always @(negedge clock) begin
        assert ($onehot0(gnt)) else $error("gnt has more than one bit set: %b", gnt);
        assert ($onehot0(ack)) else $error("ack has more than one bit set: %b", ack);
        assert (!((|gnt) && (|ack))) else $error("gnt and ack overlap: %b %b", gnt, ack);
        assert (busy == (dut.state != IDLE)) else $error("busy disagrees with state");
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        wdata = '0;
        cycle();
        cycle();
        check("rst_q",    32'(q),    0);
        check("rst_gnt",  32'(gnt),  0);
        check("rst_ack",  32'(ack),  0);
        check("rst_busy", 32'(busy), 0);

        // Single request, fixed latency.
        reset = 1'b0;
        wdata[0 +: W] = 8'hA5;
        req = 4'b0001;
        cycle(); check("single_gnt", 32'(gnt), 'h1);
        cycle(); check("single_q", 32'(q), 'hA5); check("single_ack", 32'(ack), 'h1);
        req = '0;
        cycle(); check("single_busy", 32'(busy), 0);

        // Full contention: grant order 0,1,2,3,0.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        req   = 4'b1111;
        wdata = 32'h4030_2010;
        for (int t = 0; t < 5; t++) begin
            cycle(); check("cont_gnt", 32'(gnt), 32'd1 << (t % 4));
            cycle(); check("cont_ack", 32'(ack), 32'd1 << (t % 4));
            check("cont_q", 32'(q), 32'h10 * (t % 4 + 1));
            cycle(); check("cont_idle", 32'(busy), 0);
        end

        // Wrap: a write by 2 leaves ptr=3, so 3 beats 0, then 0 follows.
        reset = 1'b1;
        req   = '0;
        cycle();
        reset = 1'b0;
        req   = 4'b0100;
        cycle(); check("wrap_gnt2", 32'(gnt), 'h4);
        cycle();
        req = 4'b1001;
        cycle();
        cycle(); check("wrap_gnt3", 32'(gnt), 'h8);
        cycle(); check("wrap_ack3", 32'(ack), 'h8);
        req = 4'b0001;
        cycle();
        cycle(); check("wrap_gnt0", 32'(gnt), 'h1);
        cycle();
        req = '0;
        cycle();

        // Request dropped during WRITE still commits.
        wdata[1*W +: W] = 8'h5C;
        req = 4'b0010;
        cycle(); check("drop_gnt", 32'(gnt), 'h2);
        req = '0;
        cycle(); check("drop_q", 32'(q), 'h5C); check("drop_ack", 32'(ack), 'h2);
        cycle();

        // Reset during WRITE aborts, and the pointer restarts at 0.
        wdata[0 +: W] = 8'h11;
        req = 4'b0001;
        cycle();
        cycle();
        req = '0;
        cycle(); check("abort_q_pre", 32'(q), 'h11);
        req = 4'b0100;
        cycle(); check("abort_gnt", 32'(gnt), 'h4);
        reset = 1'b1;
        cycle();
        check("abort_q", 32'(q), 0);
        check("abort_ack", 32'(ack), 0);
        check("abort_busy", 32'(busy), 0);
        reset = 1'b0;
        req   = 4'b0011;
        cycle(); check("abort_next_gnt", 32'(gnt), 'h1);
        cycle();
        req = 4'b0010;
        cycle();

        // Randomized requesters: raise at random, hold until ack, occasionally drop in WRITE; rare resets.
        repeat (1500) begin
            cycle();
            reset = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < N; i++) begin
                wdata[i*W +: W] = W'($urandom);
                if (req[i] && ack[i])
                    req[i] = 1'b0;
                else if (req[i] && gnt[i] && $urandom_range(0, 7) == 0)
                    req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0)
                    req[i] = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
